// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-unit parameter defaults and the fetch FSM
// state encoding.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'd0;
    localparam int unsigned DEFAULT_IMEM_DEPTH = 256;
    localparam logic [31:0] DEFAULT_HALT_WORD  = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_NOP_WORD   = 32'h0000_0000;

    // Fetch FSM encoding (one bit, kept as plain constants for legacy users)
    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction, PC and valid bit handed to decode.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   load                - capture fetch_instruction/fetch_pc as a valid entry
//   bubble              - capture NOP_WORD with valid=0, PC taken from fetch_pc
//   fetch_instruction   - word from instruction memory
//   fetch_pc            - PC associated with this cycle's fetch
//   if_id_instruction, if_id_pc, if_id_valid - registered outputs
// With neither load nor bubble the register holds.
module if_id_register
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] fetch_instruction,
    input  logic [31:0] fetch_pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instruction <= NOP_WORD;
            if_id_pc          <= RESET_PC;
            if_id_valid       <= 1'b0;
        end else if (bubble) begin
            if_id_instruction <= NOP_WORD;
            if_id_pc          <= fetch_pc;
            if_id_valid       <= 1'b0;
        end else if (load) begin
            if_id_instruction <= fetch_instruction;
            if_id_pc          <= fetch_pc;
            if_id_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, RUN/HALT FSM and
// the IF/ID pipeline register.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   stall                        - hold PC and IF/ID
//   flush                        - next IF/ID load becomes a bubble
//   branch_taken, branch_target  - redirect request and word-index target
//   program_counter              - word index presented to instruction memory
//   instruction                  - combinational memory data for program_counter
//   if_id_instruction/pc/valid   - registered fetch result for decode
//   halted                       - FSM is in HALT
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD,
    parameter logic [31:0] NOP_WORD   = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] program_counter,
    input  logic [31:0] instruction,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    localparam int unsigned ADDR_W  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] PC_MASK = 32'((64'd1 << ADDR_W) - 64'd1);
    localparam logic [31:0] LAST_PC = 32'(IMEM_DEPTH - 1);

    logic        state;
    logic        state_next;
    logic [31:0] pc_next;
    logic [31:0] pc_incr;
    logic        ifid_load;
    logic        ifid_bubble;

    assign pc_incr = (program_counter == LAST_PC) ? '0 : program_counter + 32'd1;
    assign halted  = (state == STATE_HALT);

    // Priority: branch, then stall, then HALT, then normal fetch. Reset is
    // applied on top of this in the registers themselves.
    always_comb begin
        pc_next     = program_counter;
        state_next  = state;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (branch_taken) begin
            pc_next     = branch_target & PC_MASK;
            state_next  = STATE_RUN;
            ifid_bubble = 1'b1;
        end else if (!stall) begin
            if (state == STATE_HALT) begin
                ifid_bubble = 1'b1;
            end else if (flush) begin
                ifid_bubble = 1'b1;
                pc_next     = pc_incr;
            end else begin
                ifid_load = 1'b1;
                // The halt word itself still reaches decode; the PC parks on it.
                if (instruction == HALT_WORD) begin
                    state_next = STATE_HALT;
                end else begin
                    pc_next = pc_incr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            program_counter <= RESET_PC;
            state           <= STATE_RUN;
        end else begin
            program_counter <= pc_next;
            state           <= state_next;
        end
    end

    if_id_register #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk               (clk),
        .reset             (reset),
        .load              (ifid_load),
        .bubble            (ifid_bubble),
        .fetch_instruction (instruction),
        .fetch_pc          (program_counter),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic        valid;
        logic        halted;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] program_counter, instruction;
    logic [31:0] if_id_instruction, if_id_pc;
    logic        if_id_valid, halted;

    logic        reset1;
    logic [31:0] program_counter1, instruction1;
    logic [31:0] if_id_instruction1, if_id_pc1;
    logic        if_id_valid1, halted1;

    logic [31:0] mem [256];
    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign instruction  = mem[program_counter[7:0]];
    assign instruction1 = mem[program_counter1[7:0]];

    fetch_unit u_dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .program_counter   (program_counter),
        .instruction       (instruction),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
    );

    fetch_unit #(.RESET_PC(32'd254)) u_wrap (
        .clk               (clk),
        .reset             (reset1),
        .stall             (1'b0),
        .flush             (1'b0),
        .branch_taken      (1'b0),
        .branch_target     (32'd0),
        .program_counter   (program_counter1),
        .instruction       (instruction1),
        .if_id_instruction (if_id_instruction1),
        .if_id_pc          (if_id_pc1),
        .if_id_valid       (if_id_valid1),
        .halted            (halted1)
    );

    function automatic logic [31:0] word(input int unsigned a);
        return 32'hA000_0000 | 32'(a);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls, push expected post-edge state, then pop and check.
    task automatic step(input string tag, input bit sel, input logic rst, input logic stl,
                        input logic fl, input logic br, input logic [31:0] tgt,
                        input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                        input logic e_valid, input logic e_halted, input logic [31:0] e_pc);
        exp_t e;
        if (sel) reset1 = rst;
        else reset = rst;
        stall = stl; flush = fl; branch_taken = br; branch_target = tgt;
        sb.push_back('{e_instr, e_ifpc, e_valid, e_halted, e_pc});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (!sel) begin
            chk32({tag, ".instr"},  if_id_instruction, e.instr);
            chk32({tag, ".ifpc"},   if_id_pc, e.ifpc);
            chk32({tag, ".valid"},  32'(if_id_valid), 32'(e.valid));
            chk32({tag, ".halted"}, 32'(halted), 32'(e.halted));
            chk32({tag, ".pc"},     program_counter, e.pc);
        end else begin
            chk32({tag, ".instr"},  if_id_instruction1, e.instr);
            chk32({tag, ".ifpc"},   if_id_pc1, e.ifpc);
            chk32({tag, ".valid"},  32'(if_id_valid1), 32'(e.valid));
            chk32({tag, ".halted"}, 32'(halted1), 32'(e.halted));
            chk32({tag, ".pc"},     program_counter1, e.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        mem[7] = HALT;
        reset1 = 1'b1;

        // Reset state
        step("reset",  0, 1, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
        // Sequential fetch 0..3
        step("seq0",   0, 0, 0, 0, 0, 0, word(0), 0, 1, 0, 1);
        step("seq1",   0, 0, 0, 0, 0, 0, word(1), 1, 1, 0, 2);
        step("seq2",   0, 0, 0, 0, 0, 0, word(2), 2, 1, 0, 3);
        step("seq3",   0, 0, 0, 0, 0, 0, word(3), 3, 1, 0, 4);

        // Branch at PC=2 to 10
        step("rst2",   0, 1, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
        step("b_pc1",  0, 0, 0, 0, 0, 0, word(0), 0, 1, 0, 1);
        step("b_pc2",  0, 0, 0, 0, 0, 0, word(1), 1, 1, 0, 2);
        step("br10",   0, 0, 0, 0, 1, 10, NOP, 2, 0, 0, 10);
        step("at10",   0, 0, 0, 0, 0, 0, word(10), 10, 1, 0, 11);
        // Branch with target masked to 8 bits (0x104 -> 4) while stalled
        step("brmask", 0, 0, 1, 0, 1, 32'h0000_0104, NOP, 11, 0, 0, 4);
        step("at4",    0, 0, 0, 0, 0, 0, word(4), 4, 1, 0, 5);
        // Stall three cycles at PC=5
        step("stall1", 0, 0, 1, 0, 0, 0, word(4), 4, 1, 0, 5);
        step("stall2", 0, 0, 1, 0, 0, 0, word(4), 4, 1, 0, 5);
        step("stall3", 0, 0, 1, 0, 0, 0, word(4), 4, 1, 0, 5);
        step("resume", 0, 0, 0, 0, 0, 0, word(5), 5, 1, 0, 6);
        // Flush with stall is ignored; flush alone bubbles and advances
        step("flstl",  0, 0, 1, 1, 0, 0, word(5), 5, 1, 0, 6);
        step("flush",  0, 0, 0, 1, 0, 0, NOP, 6, 0, 0, 7);
        // HALT word at 7
        step("halt",   0, 0, 0, 0, 0, 0, HALT, 7, 1, 1, 7);
        step("hbub",   0, 0, 0, 0, 0, 0, NOP, 7, 0, 1, 7);
        step("hstall", 0, 0, 1, 0, 0, 0, NOP, 7, 0, 1, 7);
        step("hbr0",   0, 0, 0, 0, 1, 0, NOP, 7, 0, 0, 0);
        step("hres",   0, 0, 0, 0, 0, 0, word(0), 0, 1, 0, 1);
        // HALT word fetched under flush does not halt
        step("to7",    0, 0, 0, 0, 1, 7, NOP, 1, 0, 0, 7);
        step("flh7",   0, 0, 0, 1, 0, 0, NOP, 7, 0, 0, 8);
        // Reset while halted and stalled
        step("to7b",   0, 0, 0, 0, 1, 7, NOP, 8, 0, 0, 7);
        step("halt2",  0, 0, 0, 0, 0, 0, HALT, 7, 1, 1, 7);
        step("rsthlt", 0, 1, 1, 0, 0, 0, NOP, 0, 0, 0, 0);
        step("post",   0, 0, 0, 0, 0, 0, word(0), 0, 1, 0, 1);

        // Wrap with RESET_PC=254
        reset = 1'b1;
        step("wrst",   1, 1, 0, 0, 0, 0, NOP, 254, 0, 0, 254);
        step("w254",   1, 0, 0, 0, 0, 0, word(254), 254, 1, 0, 255);
        step("w255",   1, 0, 0, 0, 0, 0, word(255), 255, 1, 0, 0);
        step("w0",     1, 0, 0, 0, 0, 0, word(0), 0, 1, 0, 1);
        step("w1",     1, 0, 0, 0, 0, 0, word(1), 1, 1, 0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
